debug_cmd_sequencer: RTL and testbench

DEBUG_CMD_SEQUENCER -- requirements
Module: debug_cmd_sequencer

---
 rtl/debug_pkg.sv | 22 ++
 rtl/word_byte_shifter.sv | 36 +++
 rtl/debug_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_debug_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared command codes and one-hot state bit positions for the debug command sequencer.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_EXEC = 8'h07;
    localparam logic [7:0] CMD_EXIT = 8'h08;

    localparam int ST_IDLE       = 0;
    localparam int ST_IM_LOAD    = 1;
    localparam int ST_IM_WRITE   = 2;
    localparam int ST_RUN        = 3;
    localparam int ST_STEP_IDLE  = 4;
    localparam int ST_STEP_EXEC  = 5;
    localparam int ST_DUMP_FETCH = 6;
    localparam int ST_DUMP_SEND  = 7;
    localparam int ST_DUMP_WAIT  = 8;
    localparam int ST_HALTED     = 9;
    localparam int N_STATES      = 10;

endpackage

// File: rtl/word_byte_shifter.sv
// One shift register shared by instruction-byte packing (shift in at the LSB end)
// and dump serialization (load a word, present and shift out MSB byte first).
module word_byte_shifter #(
    parameter int NB_DATA = 8,
    parameter int NB_WORD = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_shift_in,
    input  logic [NB_DATA-1:0] i_byte,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_shift_out,
    output logic [NB_WORD-1:0] o_word,
    output logic [NB_DATA-1:0] o_byte
);

    logic [NB_WORD-1:0] word_q;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            word_q <= '0;
        end else if (i_load) begin
            word_q <= i_word;
        end else if (i_shift_in) begin
            word_q <= {word_q[NB_WORD-NB_DATA-1:0], i_byte};
        end else if (i_shift_out) begin
            word_q <= {word_q[NB_WORD-NB_DATA-1:0], {NB_DATA{1'b0}}};
        end
    end

    assign o_word = word_q;
    assign o_byte = word_q[NB_WORD-1 -: NB_DATA];

endmodule

// File: rtl/debug_cmd_sequencer.sv
// UART-driven debug sequencer: instruction-memory load, run/step control and state dump.
// Optional macro DEBUG_RX_TIMEOUT_EN aborts a stalled IM load after TIMEOUT_CYCLES idle cycles.
module debug_cmd_sequencer
    import debug_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_WORD        = 32,
    parameter int IM_BYTES       = 256,
    parameter int DUMP_WORDS     = 65,
    parameter int NB_ST          = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic               i_tx_done_tick,
    input  logic               i_halt,
    input  logic [NB_WORD-1:0] i_dump_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_cpu_enable,
    output logic               o_im_wr_en,
    output logic [7:0]         o_im_addr,
    output logic [NB_WORD-1:0] o_im_data,
    output logic [6:0]         o_dump_addr,
    output logic [NB_ST-1:0]   o_state
);

    localparam int IMC_W = $clog2(IM_BYTES + 1);

    if (NB_ST < N_STATES || NB_WORD != 4 * NB_DATA || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("debug_cmd_sequencer: unsupported parameter set");
    end

    logic [NB_ST-1:0]   state, nxt;
    logic               rx_tick_q, rx_accept;
    logic [IMC_W-1:0]   im_byte_cnt;
    logic [1:0]         byte_sel;
    logic               fetch_phase, step_mode;
    logic               load_done, last_word;
    logic               shift_in, shift_load, shift_out, timeout;
    logic [NB_WORD-1:0] shift_word;

    function automatic logic [NB_ST-1:0] go(input int idx);
        return NB_ST'(1) << idx;
    endfunction

    // A strobe held for several cycles delivers its byte only once.
    assign rx_accept = i_rx_done_tick && !rx_tick_q;
    assign load_done = (im_byte_cnt == IMC_W'(IM_BYTES));
    assign last_word = (o_dump_addr == 7'(DUMP_WORDS - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= go(ST_IDLE);
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (state[ST_IDLE]) begin
            if (rx_accept && i_rx_data == NB_DATA'(CMD_LOAD))      nxt = go(ST_IM_LOAD);
            else if (rx_accept && i_rx_data == NB_DATA'(CMD_RUN))  nxt = go(ST_RUN);
            else if (rx_accept && i_rx_data == NB_DATA'(CMD_STEP)) nxt = go(ST_STEP_IDLE);
        end else if (state[ST_IM_LOAD]) begin
            if (timeout)                                nxt = go(ST_IDLE);
            else if (rx_accept && im_byte_cnt[1:0] == 2'd3) nxt = go(ST_IM_WRITE);
        end else if (state[ST_IM_WRITE]) begin
            nxt = load_done ? go(ST_IDLE) : go(ST_IM_LOAD);
        end else if (state[ST_RUN]) begin
            if (i_halt) nxt = go(ST_DUMP_FETCH);
        end else if (state[ST_STEP_IDLE]) begin
            if (rx_accept && i_rx_data == NB_DATA'(CMD_EXEC))      nxt = go(ST_STEP_EXEC);
            else if (rx_accept && i_rx_data == NB_DATA'(CMD_EXIT)) nxt = go(ST_IDLE);
        end else if (state[ST_STEP_EXEC]) begin
            nxt = go(ST_DUMP_FETCH);
        end else if (state[ST_DUMP_FETCH]) begin
            if (fetch_phase) nxt = go(ST_DUMP_SEND);
        end else if (state[ST_DUMP_SEND]) begin
            nxt = go(ST_DUMP_WAIT);
        end else if (state[ST_DUMP_WAIT]) begin
            if (i_tx_done_tick) begin
                if (byte_sel != 2'd3)  nxt = go(ST_DUMP_SEND);
                else if (!last_word)   nxt = go(ST_DUMP_FETCH);
                else if (i_halt)       nxt = go(ST_HALTED);
                else if (step_mode)    nxt = go(ST_STEP_IDLE);
                else                   nxt = go(ST_IDLE);
            end
        end else if (state[ST_HALTED]) begin
            if (rx_accept && i_rx_data == NB_DATA'(CMD_LOAD)) nxt = go(ST_IM_LOAD);
        end else begin
            nxt = go(ST_IDLE);
        end
    end

    always_comb begin
        o_cpu_enable = state[ST_STEP_EXEC] || (state[ST_RUN] && !i_halt);
        o_im_wr_en   = state[ST_IM_WRITE];
        o_tx_start   = state[ST_DUMP_SEND];
        shift_in     = state[ST_IM_LOAD] && rx_accept;
        shift_load   = state[ST_DUMP_FETCH] && fetch_phase;
        shift_out    = state[ST_DUMP_WAIT] && i_tx_done_tick;
    end

    // Dump memory returns data one cycle after the address, so FETCH spans two cycles.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_tick_q   <= 1'b0;
            im_byte_cnt <= '0;
            o_im_addr   <= '0;
            byte_sel    <= '0;
            o_dump_addr <= '0;
            fetch_phase <= 1'b0;
            step_mode   <= 1'b0;
        end else begin
            rx_tick_q   <= i_rx_done_tick;
            fetch_phase <= state[ST_DUMP_FETCH] && !fetch_phase;
            if (timeout) begin
                im_byte_cnt <= '0;
                o_im_addr   <= '0;
            end else if (shift_in) begin
                im_byte_cnt <= im_byte_cnt + IMC_W'(1);
            end
            if (state[ST_IM_WRITE]) begin
                if (load_done) begin
                    im_byte_cnt <= '0;
                    o_im_addr   <= '0;
                end else begin
                    o_im_addr <= o_im_addr + 8'd1;
                end
            end
            if (shift_out) begin
                byte_sel <= byte_sel + 2'd1;
                if (byte_sel == 2'd3) o_dump_addr <= last_word ? 7'd0 : o_dump_addr + 7'd1;
            end
            if (state[ST_STEP_EXEC])  step_mode <= 1'b1;
            else if (state[ST_RUN])   step_mode <= 1'b0;
        end
    end

`ifdef DEBUG_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset || !state[ST_IM_LOAD] || rx_accept) idle_cnt <= '0;
        else if (!timeout)                              idle_cnt <= idle_cnt + TO_W'(1);
    end

    assign timeout = state[ST_IM_LOAD] && !rx_accept && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    word_byte_shifter #(
        .NB_DATA (NB_DATA),
        .NB_WORD (NB_WORD)
    ) u_shifter (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (timeout),
        .i_shift_in  (shift_in),
        .i_byte      (i_rx_data),
        .i_load      (shift_load),
        .i_word      (i_dump_data),
        .i_shift_out (shift_out),
        .o_word      (shift_word),
        .o_byte      (o_tx_data)
    );

    assign o_im_data = shift_word;
    assign o_state   = state;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Scoreboard bench for debug_cmd_sequencer: random IM loads and dumps against a byte-level model.
// Build with DEBUG_RX_TIMEOUT_EN to exercise the IM-load inactivity abort.
module tb_debug_cmd_sequencer;

    localparam int TO = 100;
    localparam int S_IDLE = 0, S_IM_LOAD = 1, S_RUN = 3, S_STEP_IDLE = 4;
    localparam int S_DUMP_FETCH = 6, S_DUMP_WAIT = 8, S_HALTED = 9;
    localparam int DUMP_BYTES = 65 * 4;

    logic        clk = 1'b0;
    logic        i_reset, i_rx_done_tick, i_tx_done_tick, i_halt;
    logic [7:0]  i_rx_data;
    logic [31:0] i_dump_data;
    logic        o_tx_start, o_cpu_enable, o_im_wr_en;
    logic [7:0]  o_tx_data, o_im_addr;
    logic [31:0] o_im_data;
    logic [6:0]  o_dump_addr;
    logic [9:0]  o_state;

    logic [31:0] dump_mem [0:127];
    logic [7:0]  exp_tx_q[$];
    logic [39:0] exp_im_q[$];
    logic [7:0]  last_tx;
    int total = 0, bad = 0;
    int tx_cnt = 0, wr_cnt = 0, en_cnt = 0;

    always #5 clk = ~clk;

    debug_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_rx_data      (i_rx_data),
        .i_rx_done_tick (i_rx_done_tick),
        .i_tx_done_tick (i_tx_done_tick),
        .i_halt         (i_halt),
        .i_dump_data    (i_dump_data),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_cpu_enable   (o_cpu_enable),
        .o_im_wr_en     (o_im_wr_en),
        .o_im_addr      (o_im_addr),
        .o_im_data      (o_im_data),
        .o_dump_addr    (o_dump_addr),
        .o_state        (o_state)
    );

    // Registered-read dump memory: data appears one cycle after the address.
    always @(posedge clk) i_dump_data <= dump_mem[o_dump_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int len);
        i_rx_data = b;
        i_rx_done_tick = 1'b1;
        tick(len);
        i_rx_done_tick = 1'b0;
        tick($urandom_range(1, 3));
    endtask

    task automatic wait_state(input int idx, input int budget, input string name);
        int n;
        n = 0;
        while (o_state !== (10'b1 << idx) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, o_state, 10'b1 << idx);
    endtask

    task automatic push_dump();
        for (int w = 0; w < 65; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] m;
                m = dump_mem[w];
                exp_tx_q.push_back(m[31-8*k -: 8]);
            end
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick(2);
        i_reset = 1'b0;
        exp_tx_q.delete();
        exp_im_q.delete();
        tick(1);
    endtask

    // UART transmitter model: finishes each requested byte after a random delay.
    initial begin
        i_tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start && !i_reset) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 i_tx_done_tick = 1'b1;
                @(posedge clk);
                #1 i_tx_done_tick = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes IM or starts a byte.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_cpu_enable) en_cnt++;
            if (o_im_wr_en) begin
                wr_cnt++;
                check("im_q_nonempty", exp_im_q.size() != 0, 1);
                if (exp_im_q.size() != 0) check("im_write", {o_im_addr, o_im_data}, exp_im_q.pop_front());
            end
            if (o_tx_start) begin
                tx_cnt++;
                last_tx = o_tx_data;
                check("tx_q_nonempty", exp_tx_q.size() != 0, 1);
                if (exp_tx_q.size() != 0) check("tx_byte", o_tx_data, exp_tx_q.pop_front());
            end
            if (i_tx_done_tick && o_state[S_DUMP_WAIT]) check("tx_stable", o_tx_data, last_tx);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] word, cw;
        int n;
        i_reset = 1'b1;
        i_rx_data = '0;
        i_rx_done_tick = 1'b0;
        i_halt = 1'b0;
        for (int i = 0; i < 128; i++) dump_mem[i] = $urandom;
        tick(3);
        i_reset = 1'b0;
        tick(1);
        check("rst_state", o_state, 10'h001);
        check("rst_outputs", {o_tx_start, o_cpu_enable, o_im_wr_en, o_im_addr, o_dump_addr, o_tx_data, o_im_data}, 0);

        // Stray TX completion and unknown commands leave IDLE untouched
        i_tx_done_tick = 1'b1;
        tick(1);
        i_tx_done_tick = 1'b0;
        send_byte(8'h55, 2);
        send_byte(8'h07, 1);
        check("idle_ignore", o_state, 10'b1 << S_IDLE);

        // Single word 00 00 00 01 with two-cycle strobes
        wr_cnt = 0;
        send_byte(8'h01, 2);
        check("im_load_entry", o_state, 10'b1 << S_IM_LOAD);
        exp_im_q.push_back({8'd0, 32'h0000_0001});
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        tick(2);
        check("one_write", wr_cnt, 1);
        check("im_addr_after_one", o_im_addr, 1);
        check("im_q_drained_one", exp_im_q.size(), 0);
        do_reset();
        check("reset_mid_load", o_state, 10'b1 << S_IDLE);

        // Full random 256-byte load
        wr_cnt = 0;
        send_byte(8'h01, $urandom_range(1, 3));
        for (int w = 0; w < 64; w++) begin
            word = $urandom;
            exp_im_q.push_back({8'(w), word});
            for (int k = 0; k < 4; k++) send_byte(word[31-8*k -: 8], $urandom_range(1, 3));
        end
        wait_state(S_IDLE, 10, "load_back_idle");
        check("load_writes", wr_cnt, 64);
        check("load_addr_cleared", o_im_addr, 0);
        check("load_q_drained", exp_im_q.size(), 0);

        // Step: one enable cycle, full dump, command during dump is dropped
        send_byte(8'h03, 1);
        check("step_idle_entry", o_state, 10'b1 << S_STEP_IDLE);
        send_byte(8'h42, 2);
        check("step_idle_ignore", o_state, 10'b1 << S_STEP_IDLE);
        tx_cnt = 0;
        en_cnt = 0;
        push_dump();
        send_byte(8'h07, 2);
        tick(20);
        send_byte(8'h08, 2);
        wait_state(S_STEP_IDLE, 6000, "step_back_step_idle");
        check("step_enable_cycles", en_cnt, 1);
        check("step_tx_count", tx_cnt, DUMP_BYTES);
        check("step_q_drained", exp_tx_q.size(), 0);
        send_byte(8'h08, 1);
        check("step_exit", o_state, 10'b1 << S_IDLE);

        // Run until halt, dump, land in HALTED
        tx_cnt = 0;
        push_dump();
        send_byte(8'h02, 1);
        check("run_entry", o_state, 10'b1 << S_RUN);
        check("run_enable", o_cpu_enable, 1);
        tick(50);
        i_halt = 1'b1;
        @(negedge clk);
        check("halt_enable_drop", o_cpu_enable, 0);
        tick(1);
        check("halt_to_fetch", o_state, 10'b1 << S_DUMP_FETCH);
        wait_state(S_HALTED, 6000, "run_halted");
        check("run_tx_count", tx_cnt, DUMP_BYTES);
        check("run_q_drained", exp_tx_q.size(), 0);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        check("halted_ignore", o_state, 10'b1 << S_HALTED);
        send_byte(8'h01, 1);
        check("halted_load", o_state, 10'b1 << S_IM_LOAD);
        i_halt = 1'b0;
        do_reset();

        // Reset in the middle of a dump
        tx_cnt = 0;
        send_byte(8'h03, 1);
        push_dump();
        send_byte(8'h07, 1);
        n = 0;
        while (tx_cnt < 10 && n < 2000) begin
            tick(1);
            n++;
        end
        check("dump_reached_10", tx_cnt >= 10, 1);
        i_reset = 1'b1;
        tick(1);
        check("mid_dump_reset_state", o_state, 10'b1 << S_IDLE);
        check("mid_dump_reset_tx", o_tx_start, 0);
        i_reset = 1'b0;
        exp_tx_q.delete();
        tick(10);
        check("mid_dump_stays_idle", o_state, 10'b1 << S_IDLE);
        check("mid_dump_addr_clear", o_dump_addr, 0);

        // Stalled load: two bytes, then silence
        wr_cnt = 0;
        word = $urandom;
        send_byte(8'h01, 1);
        send_byte(word[31:24], 1);
        send_byte(word[23:16], 1);
        tick(TO + 20);
`ifdef DEBUG_RX_TIMEOUT_EN
        check("timeout_idle", o_state, 10'b1 << S_IDLE);
        check("timeout_no_write", wr_cnt, 0);
        cw = $urandom;
        exp_im_q.push_back({8'd0, cw});
        send_byte(8'h01, 1);
        for (int k = 0; k < 4; k++) send_byte(cw[31-8*k -: 8], 1);
`else
        check("no_timeout_stays", o_state, 10'b1 << S_IM_LOAD);
        check("no_timeout_no_write", wr_cnt, 0);
        cw = word;
        exp_im_q.push_back({8'd0, cw});
        send_byte(word[15:8], 1);
        send_byte(word[7:0], 1);
`endif
        tick(3);
        check("stall_write_count", wr_cnt, 1);
        check("stall_q_drained", exp_im_q.size(), 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
